stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshake on every input and on the output.
- The data path is built from generate-replicated narrow slice muxes of SLICE_W bits each.
- Output is registered and carries the source channel index.
- Two selection modes: fixed (external select) and round-robin arbitration. It sits between several producer streams and one consumer.

Parameters:
- N_CH, 4, number of input channels (≥2).
- WIDTH, 8, data width per channel. Must be a multiple of SLICE_W.
- SLICE_W, 2, width of one slice mux instance.
- CH_W, $clog2(N_CH), width of channel index (localparam, not overridable).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  CH_W  channel chosen in fixed mode.
- in_valid  in  N_CH  per-channel valid.
- in_data  in  N_CH*WIDTH  flattened data; channel k occupies [k*WIDTH +: WIDTH].
- in_ready  out  N_CH  per-channel ready.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered data.
- out_ch  out  CH_W  channel index of out_data.
- out_ready  in  1  consumer accepts.

Behaviour:
- Reset (rst high at posedge):
  - out_valid=0, out_data=0, out_ch=0.
  - RR pointer last=N_CH-1, so the first RR grant searches from ch0.
  - in_ready is all 0 while rst is high.
- Load enable: load = !out_valid || out_ready. Throughput is 1 word/cycle; latency is 1 cycle from input transfer to out_valid.
- Grant, combinational, one-hot or none:
  - Fixed mode: grant = sel if in_valid[sel], else none. Other channels are never granted, even if valid.
  - RR mode: grant is the first k with in_valid[k], searching (last+1) mod N_CH upward with wrap. The pointer channel itself is checked last.
  - sel ≥ N_CH in fixed mode: no grant.
- in_ready[k] = load && grant==k. At most one bit is set. This is a combinational path from out_ready to in_ready (documented; no skid buffer).
- Transfer on channel k when in_valid[k] && in_ready[k]. At the next posedge:
  - out_data = in_data slice k; out_ch = k; out_valid = 1.
  - In RR mode, last = k.
- If load is set with no grant: out_valid goes to 0 at the next posedge. out_data and out_ch keep their old values.
- Stall (out_valid && !out_ready): out_valid, out_data and out_ch are held stable. The RR pointer is unchanged.
- Pointer update rules:
  - The pointer advances only on a transfer in RR mode.
  - Fixed-mode transfers do not touch the pointer.
  - A mode switch takes effect on the next grant decision; the word in flight is unaffected.
- Simultaneous out_ready and new grant: the old word leaves and the new word loads in the same cycle (back-to-back, no bubble).
- Reset mid-operation: a word in the output register is discarded (out_valid=0). No in_ready is asserted during the reset cycle.
- Data path:
  - out_data next = concatenation over s=0..WIDTH/SLICE_W-1 of slice_mux_s(in_data[k*WIDTH+s*SLICE_W +: SLICE_W] for all k, grant index).
  - All slices share the same select.

Decomposition:
- Package stream_mux_pkg:
  - typedef enum logic {MODE_FIXED=0, MODE_RR=1} mux_mode_t.
  - Function rr_next(valid, last) returning grant index and a found flag.
- Sub-module mux_n_1_slice (params N_CH, SLICE_W; ports d flattened N_CH*SLICE_W, sel CH_W, y SLICE_W).
  - Purely combinational.
  - Instantiated WIDTH/SLICE_W times in a generate loop.
- Top module: grant logic, RR pointer, output register.

Test Plan:
1. Reset: hold rst 3 cycles with all in_valid=1. Required: out_valid=0, out_data=0, out_ch=0, in_ready=0000 throughout.
2. Fixed mode: mode=0, sel=2, in_valid=1111, ch2 data=8'hA5, out_ready=1. Required: in_ready=0100; next cycle out_data=A5, out_ch=2. Set sel=3 (ch3=8'h3C): following word is 3C/ch3.
3. RR fairness: mode=1, in_valid=1111, out_ready=1, data ch k = 8'h10+k. Required: out_ch sequence 0,1,2,3,0 on consecutive cycles with no bubbles; out_data 10,11,12,13,10.
4. RR skip and wrap: in_valid=1010 after last=3. Required: grants 1,3,1,3. Drop ch3 valid → grants 1,1 (the pointer channel is re-granted when it is the only requester).
5. Backpressure: RR, out_ready=0 for 4 cycles with in_valid=1111. Required: first word captured; then in_ready=0000; out_data/out_ch stable; pointer frozen. Raise out_ready: the next grant is pointer+1, and output switches with no lost or duplicated word.
6. Mid-stream reset and params: during RR traffic assert rst 1 cycle. Required: out_valid=0; the next grant goes to ch0. Repeat tests 2–3 with N_CH=3, WIDTH=12, SLICE_W=4. Required: wrap 2→0; all 12 bits correct; sel=3 in fixed mode gives no grant.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// rtl/stream_mux_rr_pkg.sv - shared types and round-robin search helper for stream_mux_rr
package stream_mux_pkg;

  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_t;

  localparam int MAX_CH = 32;
  localparam int IDX_W  = 5;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_grant_t;

  // Search starts one past the pointer and wraps; the pointer channel is checked last.
  function automatic rr_grant_t rr_next(input logic [MAX_CH-1:0] valid,
                                        input int unsigned last,
                                        input int unsigned n_ch);
    rr_grant_t g;
    int unsigned k;
    g.found = 1'b0;
    g.idx   = '0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      k = last + i;
      if (k >= n_ch) k = k - n_ch;
      if (i <= n_ch && !g.found && valid[k[IDX_W-1:0]]) begin
        g.found = 1'b1;
        g.idx   = k[IDX_W-1:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - producer-side and consumer-side handshake bundle of the mux
interface stream_mux_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [CH_W-1:0]       out_ch;
  logic                  out_ready;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/stream_mux_rr_slice.sv
// rtl/stream_mux_rr_slice.sv - combinational N:1 mux of one SLICE_W-bit data slice
module mux_n_1_slice #(
  parameter int N_CH    = 4,
  parameter int SLICE_W = 2,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic [N_CH*SLICE_W-1:0] d,
  input  logic [CH_W-1:0]         sel,
  output logic [SLICE_W-1:0]      y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == CH_W'(k)) y = d[k*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel stream mux, fixed or round-robin select, registered output
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 8,
  parameter int SLICE_W = 2,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [CH_W-1:0] sel,
  stream_mux_rr_if.master bus
);

  localparam int N_SLICE = WIDTH / SLICE_W;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic [CH_W-1:0]  last_q, last_d;

  mux_mode_t        mode_e;
  logic [MAX_CH-1:0] valid_ext;
  rr_grant_t        rr;
  logic             found;
  logic [CH_W-1:0]  grant_idx;
  logic             load;
  logic [WIDTH-1:0] mux_y;

  assign mode_e = mux_mode_t'(mode);
  assign load   = !out_valid_q || bus.out_ready;

  always_comb begin
    valid_ext = '0;
    valid_ext[N_CH-1:0] = bus.in_valid;
    rr        = rr_next(valid_ext, 32'(last_q), N_CH);
    found     = 1'b0;
    grant_idx = '0;
    if (mode_e == MODE_RR) begin
      found     = rr.found;
      grant_idx = CH_W'(rr.idx);
    end else begin
      // Out-of-range sel matches no channel and so never grants.
      for (int k = 0; k < N_CH; k++) begin
        if (sel == CH_W'(k) && bus.in_valid[k]) begin
          found     = 1'b1;
          grant_idx = CH_W'(k);
        end
      end
    end
  end

  // out_ready reaches in_ready combinationally through load.
  always_comb begin
    bus.in_ready = '0;
    for (int k = 0; k < N_CH; k++) begin
      bus.in_ready[k] = !rst && load && found && (grant_idx == CH_W'(k));
    end
  end

  for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
    logic [N_CH*SLICE_W-1:0] d;
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign d[k*SLICE_W +: SLICE_W] = bus.in_data[k*WIDTH + s*SLICE_W +: SLICE_W];
    end
    mux_n_1_slice #(.N_CH(N_CH), .SLICE_W(SLICE_W)) u_mux (
      .d  (d),
      .sel(grant_idx),
      .y  (mux_y[s*SLICE_W +: SLICE_W])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    if (load) begin
      out_valid_d = found;
      if (found) begin
        out_data_d = mux_y;
        out_ch_d   = grant_idx;
        if (mode_e == MODE_RR) last_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= CH_W'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed vector bench for stream_mux_rr in two parameter sets
module tb_stream_mux_rr;

  typedef struct {
    bit          b;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [35:0] din;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [11:0] e_od;
    logic [1:0]  e_oc;
  } vec_t;

  localparam logic [35:0] D0  = 36'h013121110;
  localparam logic [35:0] DA5 = 36'h013A51110;
  localparam logic [35:0] D3C = 36'h03CA51110;
  localparam logic [35:0] DB  = 36'h0E75F0ABC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic [1:0] sel = 2'd0;

  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  stream_mux_rr_if #(.N_CH(4), .WIDTH(8))  ifa ();
  stream_mux_rr_if #(.N_CH(3), .WIDTH(12)) ifb ();

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .SLICE_W(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .mode(mode),
    .sel (sel),
    .bus (ifa)
  );

  stream_mux_rr #(.N_CH(3), .WIDTH(12), .SLICE_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .mode(mode),
    .sel (sel),
    .bus (ifb)
  );

  function automatic vec_t mk(bit b, logic r, logic m, logic [1:0] s, logic [3:0] iv,
                              logic [35:0] din, logic ordy, logic [3:0] e_rdy,
                              logic e_ov, logic [11:0] e_od, logic [1:0] e_oc);
    vec_t v;
    v.b = b; v.rst = r; v.mode = m; v.sel = s; v.iv = iv; v.din = din; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_oc = e_oc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [35:0] act,
                       input logic [35:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    else
      n_pass++;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    rst = v.rst; mode = v.mode; sel = v.sel;
    if (!v.b) begin
      ifa.in_valid = v.iv; ifa.in_data = v.din[31:0]; ifa.out_ready = v.ordy;
    end else begin
      ifb.in_valid = v.iv[2:0]; ifb.in_data = v.din; ifb.out_ready = v.ordy;
    end
    #1;
    if (!v.b) check("in_ready", idx, 36'(ifa.in_ready), 36'(v.e_rdy));
    else      check("in_ready", idx, 36'(ifb.in_ready), 36'(v.e_rdy));
    @(posedge clk);
    #1;
    if (!v.b) begin
      check("out_valid", idx, 36'(ifa.out_valid), 36'(v.e_ov));
      check("out_data",  idx, 36'(ifa.out_data),  36'(v.e_od));
      check("out_ch",    idx, 36'(ifa.out_ch),    36'(v.e_oc));
    end else begin
      check("out_valid", idx, 36'(ifb.out_valid), 36'(v.e_ov));
      check("out_data",  idx, 36'(ifb.out_data),  36'(v.e_od));
      check("out_ch",    idx, 36'(ifb.out_ch),    36'(v.e_oc));
    end
  endtask

  initial begin
    int  cycles;
    bit  got;
    ifa.in_valid = '0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = '0; ifb.in_data = '0; ifb.out_ready = 1'b0;

    // Four-channel, 8-bit instance: reset, fixed, RR fairness/skip/wrap, stall, mid reset.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 1, 0, 4'b1111, D0, 1, 4'b0000, 0, 12'h00, 0));
    vecs.push_back(mk(0, 0, 0, 2, 4'b1111, DA5, 1, 4'b0100, 1, 12'hA5, 2));
    vecs.push_back(mk(0, 0, 0, 3, 4'b1111, D3C, 1, 4'b1000, 1, 12'h3C, 3));
    vecs.push_back(mk(0, 0, 1, 0, 4'b1111, D0, 1, 4'b0001, 1, 12'h10, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'b1111, D0, 1, 4'b0010, 1, 12'h11, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'b1111, D0, 1, 4'b0100, 1, 12'h12, 2));
    vecs.push_back(mk(0, 0, 1, 0, 4'b1111, D0, 1, 4'b1000, 1, 12'h13, 3));
    vecs.push_back(mk(0, 0, 1, 0, 4'b1111, D0, 1, 4'b0001, 1, 12'h10, 0));
    for (int i = 0; i < 2; i++) begin
      vecs.push_back(mk(0, 0, 1, 0, 4'b1010, D0, 1, 4'b0010, 1, 12'h11, 1));
      vecs.push_back(mk(0, 0, 1, 0, 4'b1010, D0, 1, 4'b1000, 1, 12'h13, 3));
    end
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(0, 0, 1, 0, 4'b0010, D0, 1, 4'b0010, 1, 12'h11, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'b0000, D0, 1, 4'b0000, 0, 12'h11, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'b1111, D0, 0, 4'b0100, 1, 12'h12, 2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 1, 0, 4'b1111, D0, 0, 4'b0000, 1, 12'h12, 2));
    vecs.push_back(mk(0, 0, 1, 0, 4'b1111, D0, 1, 4'b1000, 1, 12'h13, 3));
    vecs.push_back(mk(0, 0, 1, 0, 4'b1111, D0, 1, 4'b0001, 1, 12'h10, 0));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1111, D0, 1, 4'b0000, 0, 12'h00, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'b1111, D0, 1, 4'b0001, 1, 12'h10, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'b1101, D0, 1, 4'b0000, 0, 12'h10, 0));
    vecs.push_back(mk(0, 0, 0, 2, 4'b1111, D0, 1, 4'b0100, 1, 12'h12, 2));
    vecs.push_back(mk(0, 0, 1, 0, 4'b1111, D0, 1, 4'b0010, 1, 12'h11, 1));

    // Three-channel, 12-bit instance with 4-bit slices.
    vecs.push_back(mk(1, 1, 1, 0, 4'b0111, DB, 1, 4'b0000, 0, 12'h000, 0));
    vecs.push_back(mk(1, 0, 0, 2, 4'b0111, DB, 1, 4'b0100, 1, 12'h0E7, 2));
    vecs.push_back(mk(1, 0, 0, 3, 4'b0111, DB, 1, 4'b0000, 0, 12'h0E7, 2));
    vecs.push_back(mk(1, 0, 1, 0, 4'b0111, DB, 1, 4'b0001, 1, 12'hABC, 0));
    vecs.push_back(mk(1, 0, 1, 0, 4'b0111, DB, 1, 4'b0010, 1, 12'h5F0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 4'b0111, DB, 1, 4'b0100, 1, 12'h0E7, 2));
    vecs.push_back(mk(1, 0, 1, 0, 4'b0111, DB, 1, 4'b0001, 1, 12'hABC, 0));

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // Lone requester after reset: word must appear one cycle after the transfer.
    @(negedge clk);
    rst = 1'b1; mode = 1'b1; ifa.in_valid = 4'b0000; ifa.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; ifa.in_valid = 4'b0100; ifa.in_data = 32'h13121110;
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < 8) begin
      @(posedge clk);
      #1;
      cycles++;
      if (ifa.out_valid) got = 1'b1;
    end
    check("wait_valid", 100, 36'(got), 36'd1);
    check("wait_ch",    100, 36'(ifa.out_ch), 36'd2);
    check("wait_data",  100, 36'(ifa.out_data), 36'h12);
    check("latency",    100, 36'(cycles), 36'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
